// File: rtl/v_pkg.sv
// rtl/v_pkg.sv - shared payload types for the list update bus
// Purpose: field types of an update command and the packed command record
//          used for FIFO storage and the update bus output register.
// Ports:   none (package).
package v_pkg;

    typedef logic [7:0]  id_t;
    typedef logic [1:0]  cmd_t;
    typedef logic [15:0] key_t;
    typedef logic [7:0]  size_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

endpackage

// File: rtl/v_upd_issue_fifo.sv
// rtl/v_upd_issue_fifo.sv - circular command buffer with occupancy counter
// Purpose: DEPTH-entry FIFO holding payloads of type T.
// Ports:
//   clk, arst_n   clock, asynchronous active-low reset
//   push, wdata   write wdata at the tail (caller guarantees not full)
//   pop, rdata    rdata is the head; pop advances it (caller guarantees not empty)
//   level         registered occupancy, 0..DEPTH
//   empty, full   decoded from level
module v_upd_issue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  T                           wdata,
    input  logic                       pop,
    output T                           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    T                mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [LW-1:0]   level_q;

    // DEPTH is a power of two, so the pointers wrap without compare logic.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];
    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/v_upd_issue.sv
// rtl/v_upd_issue.sv - update bus issue stage with FIFO, bypass and hazard stall
// Purpose: accepts host update commands, buffers them, and issues at most one
//          per cycle onto the registered update bus in acceptance order.
// Configuration: V_UPD_ISSUE_HAZARD_STALL_EN enables same-product stalling
//          against the update bus register and pipeline stages S1..S4.
// Ports:
//   clk, arst_n               clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_rdy       host command handshake and payload
//   o_upd_*_r                 registered update bus
//   i_sN_upd_vld_r/prod_id_r  update pipeline stage status, N=1..4
//   o_level_r                 FIFO occupancy
//   o_busy                    FIFO non-empty or update bus valid
module v_upd_issue
    import v_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       i_cmd_vld,
    output logic                       o_cmd_rdy,
    input  id_t                        i_cmd_prod_id,
    input  cmd_t                       i_cmd_cmd,
    input  key_t                       i_cmd_key,
    input  size_t                      i_cmd_size,
    output logic                       o_upd_vld_r,
    output id_t                        o_upd_prod_id_r,
    output cmd_t                       o_upd_cmd_r,
    output key_t                       o_upd_key_r,
    output size_t                      o_upd_size_r,
    input  logic                       i_s1_upd_vld_r,
    input  id_t                        i_s1_upd_prod_id_r,
    input  logic                       i_s2_upd_vld_r,
    input  id_t                        i_s2_upd_prod_id_r,
    input  logic                       i_s3_upd_vld_r,
    input  id_t                        i_s3_upd_prod_id_r,
    input  logic                       i_s4_upd_vld_r,
    input  id_t                        i_s4_upd_prod_id_r,
    output logic [$clog2(DEPTH+1)-1:0] o_level_r,
    output logic                       o_busy
);

    upd_t in_cmd;
    upd_t head;
    upd_t cand;
    upd_t upd_r;
    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic cand_vld;
    logic stall;
    logic issue;
    logic push;
    logic pop;

    assign in_cmd = '{prod_id: i_cmd_prod_id, cmd: i_cmd_cmd,
                      key: i_cmd_key, size: i_cmd_size};

    // Ready comes from the level flop only; full blocks acceptance even
    // in a cycle that pops.
    assign o_cmd_rdy = !fifo_full;
    assign accept    = i_cmd_vld && o_cmd_rdy;

    // The head always has priority; the incoming command bypasses only
    // when nothing is buffered, which preserves acceptance order.
    assign cand_vld = !fifo_empty || accept;
    assign cand     = fifo_empty ? in_cmd : head;
    assign issue    = cand_vld && !stall;
    assign pop      = issue && !fifo_empty;
    // A bypassed command is not stored; a stalled bypass falls back to a push.
    assign push     = accept && !(fifo_empty && issue);

`ifdef V_UPD_ISSUE_HAZARD_STALL_EN
    assign stall = (o_upd_vld_r    && (upd_r.prod_id      == cand.prod_id)) ||
                   (i_s1_upd_vld_r && (i_s1_upd_prod_id_r == cand.prod_id)) ||
                   (i_s2_upd_vld_r && (i_s2_upd_prod_id_r == cand.prod_id)) ||
                   (i_s3_upd_vld_r && (i_s3_upd_prod_id_r == cand.prod_id)) ||
                   (i_s4_upd_vld_r && (i_s4_upd_prod_id_r == cand.prod_id));
`else
    assign stall = 1'b0;

    // Stage status is only consumed by the hazard check.
    logic unused_stage_status;
    assign unused_stage_status = ^{i_s1_upd_vld_r, i_s1_upd_prod_id_r,
                                   i_s2_upd_vld_r, i_s2_upd_prod_id_r,
                                   i_s3_upd_vld_r, i_s3_upd_prod_id_r,
                                   i_s4_upd_vld_r, i_s4_upd_prod_id_r};
`endif

    v_upd_issue_fifo #(
        .DEPTH (DEPTH),
        .T     (upd_t)
    ) u_fifo (
        .clk    (clk),
        .arst_n (arst_n),
        .push   (push),
        .wdata  (in_cmd),
        .pop    (pop),
        .rdata  (head),
        .level  (o_level_r),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_upd_vld_r <= 1'b0;
        end else begin
            o_upd_vld_r <= issue;
        end
    end

    // Payload holds while idle; only valid qualifies it.
    always_ff @(posedge clk) begin
        if (issue) upd_r <= cand;
    end

    assign o_upd_prod_id_r = upd_r.prod_id;
    assign o_upd_cmd_r     = upd_r.cmd;
    assign o_upd_key_r     = upd_r.key;
    assign o_upd_size_r    = upd_r.size;
    assign o_busy          = !fifo_empty || o_upd_vld_r;

endmodule

// File: tb/tb_v_upd_issue.sv
// tb/tb_v_upd_issue.sv - self-checking bench for v_upd_issue
module tb_v_upd_issue;
    import v_pkg::*;

    localparam int DEPTH = 4;
`ifdef V_UPD_ISSUE_HAZARD_STALL_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        i_cmd_vld = 1'b0;
    upd_t        cmd_in = '0;
    logic        o_cmd_rdy;
    logic        o_upd_vld_r;
    id_t         o_upd_prod_id_r;
    cmd_t        o_upd_cmd_r;
    key_t        o_upd_key_r;
    size_t       o_upd_size_r;
    logic        s_vld [4];
    id_t         s_id  [4];
    logic [2:0]  o_level_r;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    // Reference model: commands pending in acceptance order, plus the bus register.
    upd_t mq[$];
    logic m_vld = 1'b0;
    upd_t m_upd = '0;

    always #5 clk = ~clk;

    v_upd_issue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .arst_n             (arst_n),
        .i_cmd_vld          (i_cmd_vld),
        .o_cmd_rdy          (o_cmd_rdy),
        .i_cmd_prod_id      (cmd_in.prod_id),
        .i_cmd_cmd          (cmd_in.cmd),
        .i_cmd_key          (cmd_in.key),
        .i_cmd_size         (cmd_in.size),
        .o_upd_vld_r        (o_upd_vld_r),
        .o_upd_prod_id_r    (o_upd_prod_id_r),
        .o_upd_cmd_r        (o_upd_cmd_r),
        .o_upd_key_r        (o_upd_key_r),
        .o_upd_size_r       (o_upd_size_r),
        .i_s1_upd_vld_r     (s_vld[0]),
        .i_s1_upd_prod_id_r (s_id[0]),
        .i_s2_upd_vld_r     (s_vld[1]),
        .i_s2_upd_prod_id_r (s_id[1]),
        .i_s3_upd_vld_r     (s_vld[2]),
        .i_s3_upd_prod_id_r (s_id[2]),
        .i_s4_upd_vld_r     (s_vld[3]),
        .i_s4_upd_prod_id_r (s_id[3]),
        .o_level_r          (o_level_r),
        .o_busy             (o_busy)
    );

    function automatic upd_t dut_upd();
        return '{prod_id: o_upd_prod_id_r, cmd: o_upd_cmd_r,
                 key: o_upd_key_r, size: o_upd_size_r};
    endfunction

    function automatic upd_t mk(input int id, input int key, input int size);
        upd_t c;
        c.prod_id = id_t'(id);
        c.cmd     = cmd_t'(id);
        c.key     = key_t'(key);
        c.size    = size_t'(size);
        return c;
    endfunction

    function automatic upd_t rnd_cmd();
        upd_t c;
        c.prod_id = id_t'($urandom_range(0, 3));
        c.cmd     = cmd_t'($urandom);
        c.key     = key_t'($urandom);
        c.size    = size_t'($urandom);
        return c;
    endfunction

    // A candidate is blocked when its product is on the bus or in any stage.
    function automatic logic model_stall(input upd_t c);
        logic hit;
        hit = m_vld && (m_upd.prod_id == c.prod_id);
        for (int k = 0; k < 4; k++)
            if (s_vld[k] && (s_id[k] == c.prod_id)) hit = 1'b1;
        return HAZARD_EN && hit;
    endfunction

    task automatic clear_stages();
        for (int k = 0; k < 4; k++) begin
            s_vld[k] = 1'b0;
            s_id[k]  = '0;
        end
    endtask

    // Drive one cycle of host input, advance the model, return at edge+1.
    task automatic tick(input logic v, input upd_t c, output logic acc);
        i_cmd_vld = v;
        cmd_in    = c;
        acc = v && (mq.size() != DEPTH);
        if (acc) mq.push_back(c);
        if (mq.size() != 0 && !model_stall(mq[0])) begin
            m_vld = 1'b1;
            m_upd = mq.pop_front();
        end else begin
            m_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        i_cmd_vld = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        clear_stages();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_upd_vld_r !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", o_upd_vld_r); end
        checks++; if (o_level_r !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", o_level_r); end
        checks++; if (o_cmd_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", o_cmd_rdy); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic acc;
        upd_t c;
        c = mk(3, 'h10, 5);
        tick(1'b1, c, acc);
        checks++; if (o_upd_vld_r !== 1'b1) begin errors++; $display("FAIL single_vld got %b exp 1", o_upd_vld_r); end
        checks++; if (dut_upd() !== c) begin errors++; $display("FAIL single_payload got %h exp %h", dut_upd(), c); end
        checks++; if (o_level_r !== 3'd0) begin errors++; $display("FAIL single_level got %0d exp 0", o_level_r); end
        tick(1'b0, c, acc);
        checks++; if (o_upd_vld_r !== 1'b0) begin errors++; $display("FAIL single_idle_vld got %b exp 0", o_upd_vld_r); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        upd_t c [6];
        for (int i = 0; i < 6; i++) c[i] = mk(8 + i, 'h100 + i, i);
        for (int i = 0; i < 6; i++) begin
            checks++; if (o_cmd_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d] got %b exp 1", i, o_cmd_rdy); end
            tick(1'b1, c[i], acc);
            checks++;
            if (o_upd_vld_r !== 1'b1 || dut_upd() !== c[i]) begin
                errors++; $display("FAIL b2b_issue[%0d] got vld %b %h exp 1 %h", i, o_upd_vld_r, dut_upd(), c[i]);
            end
        end
        tick(1'b0, c[0], acc);
    endtask

`ifdef V_UPD_ISSUE_HAZARD_STALL_EN
    task automatic test_hazard_order();
        logic acc;
        s_vld[1] = 1'b1; s_id[1] = id_t'(7);
        tick(1'b1, mk(7, 'h70, 1), acc);
        tick(1'b1, mk(8, 'h80, 2), acc);
        repeat (3) begin
            checks++; if (o_upd_vld_r !== 1'b0) begin errors++; $display("FAIL hz_hold_vld got %b exp 0", o_upd_vld_r); end
            tick(1'b0, '0, acc);
        end
        checks++; if (o_level_r !== 3'd2) begin errors++; $display("FAIL hz_hold_level got %0d exp 2", o_level_r); end
        clear_stages();
        tick(1'b0, '0, acc);
        checks++; if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== id_t'(7)) begin
            errors++; $display("FAIL hz_first got vld %b id %0d exp 1 7", o_upd_vld_r, o_upd_prod_id_r); end
        tick(1'b0, '0, acc);
        checks++; if (o_upd_vld_r !== 1'b1 || o_upd_prod_id_r !== id_t'(8)) begin
            errors++; $display("FAIL hz_second got vld %b id %0d exp 1 8", o_upd_vld_r, o_upd_prod_id_r); end
        tick(1'b0, '0, acc);
    endtask

    task automatic test_hazard_full();
        logic acc;
        upd_t c [5];
        int idx = 0;
        int got [$];
        for (int i = 0; i < 5; i++) c[i] = mk(9 + i, 'h900 + i, i);
        s_vld[3] = 1'b1; s_id[3] = id_t'(9);
        repeat (6) begin
            tick(1'b1, c[idx], acc);
            if (acc) idx++;
        end
        checks++; if (o_level_r !== 3'd4) begin errors++; $display("FAIL full_level got %0d exp 4", o_level_r); end
        checks++; if (o_cmd_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %b exp 0", o_cmd_rdy); end
        checks++; if (idx !== 4) begin errors++; $display("FAIL full_accepted got %0d exp 4", idx); end
        clear_stages();
        tick(1'b1, c[idx], acc);
        if (acc) idx++;
        if (o_upd_vld_r === 1'b1) got.push_back(int'(o_upd_prod_id_r));
        checks++; if (o_cmd_rdy !== 1'b1 || o_level_r !== 3'd3) begin
            errors++; $display("FAIL full_first_pop got rdy %b level %0d exp 1 3", o_cmd_rdy, o_level_r); end
        for (int n = 0; n < 20 && got.size() < 5; n++) begin
            tick(idx < 5, c[idx < 5 ? idx : 0], acc);
            if (acc) idx++;
            if (o_upd_vld_r === 1'b1) got.push_back(int'(o_upd_prod_id_r));
        end
        checks++; if (got.size() !== 5) begin errors++; $display("FAIL full_drain_count got %0d exp 5", got.size()); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++; if (got[i] !== 9 + i) begin errors++; $display("FAIL full_order[%0d] got %0d exp %0d", i, got[i], 9 + i); end
        end
    endtask
`else
    task automatic test_same_product();
        logic acc;
        for (int k = 0; k < 4; k++) begin
            s_vld[k] = 1'b1; s_id[k] = id_t'(2);
        end
        tick(1'b1, mk(2, 'h21, 1), acc);
        checks++; if (o_upd_vld_r !== 1'b1 || o_upd_key_r !== key_t'('h21)) begin
            errors++; $display("FAIL same_first got vld %b key %h exp 1 0021", o_upd_vld_r, o_upd_key_r); end
        tick(1'b1, mk(2, 'h22, 2), acc);
        checks++; if (o_upd_vld_r !== 1'b1 || o_upd_key_r !== key_t'('h22)) begin
            errors++; $display("FAIL same_second got vld %b key %h exp 1 0022", o_upd_vld_r, o_upd_key_r); end
        clear_stages();
        tick(1'b0, '0, acc);
    endtask
`endif

    task automatic test_random();
        logic acc;
        logic hold = 1'b0;
        upd_t c = '0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 4; k++) begin
                s_vld[k] = ($urandom_range(0, 3) == 0);
                s_id[k]  = id_t'($urandom_range(0, 3));
            end
            if (!hold) c = rnd_cmd();
            hold = hold || ($urandom_range(0, 2) != 0);
            tick(hold, c, acc);
            if (acc) hold = 1'b0;
            checks++; if (o_upd_vld_r !== m_vld) begin errors++; $display("FAIL rnd_vld[%0d] got %b exp %b", n, o_upd_vld_r, m_vld); end
            checks++; if (m_vld && dut_upd() !== m_upd) begin errors++; $display("FAIL rnd_payload[%0d] got %h exp %h", n, dut_upd(), m_upd); end
            checks++; if (int'(o_level_r) !== mq.size()) begin errors++; $display("FAIL rnd_level[%0d] got %0d exp %0d", n, o_level_r, mq.size()); end
            checks++; if (o_cmd_rdy !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_rdy[%0d] got %b", n, o_cmd_rdy); end
            checks++; if (o_busy !== (mq.size() != 0 || m_vld)) begin errors++; $display("FAIL rnd_busy[%0d] got %b", n, o_busy); end
        end
        clear_stages();
        for (int n = 0; n < 10; n++) tick(1'b0, '0, acc);
    endtask

    task automatic test_reset_midway();
        logic acc;
        upd_t fresh;
`ifdef V_UPD_ISSUE_HAZARD_STALL_EN
        s_vld[0] = 1'b1; s_id[0] = id_t'(1);
        for (int i = 0; i < 3; i++) tick(1'b1, mk(1 + i, 'h300 + i, i), acc);
        checks++; if (o_level_r !== 3'd3) begin errors++; $display("FAIL rst_pre_level got %0d exp 3", o_level_r); end
`else
        tick(1'b1, mk(1, 'h300, 0), acc);
        checks++; if (o_upd_vld_r !== 1'b1) begin errors++; $display("FAIL rst_pre_vld got %b exp 1", o_upd_vld_r); end
`endif
        i_cmd_vld = 1'b1;
        cmd_in    = mk(3, 'h333, 3);
        arst_n    = 1'b0;
        #1;
        checks++; if (o_upd_vld_r !== 1'b0) begin errors++; $display("FAIL rst_mid_vld got %b exp 0", o_upd_vld_r); end
        checks++; if (o_level_r !== 3'd0) begin errors++; $display("FAIL rst_mid_level got %0d exp 0", o_level_r); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", o_busy); end
        i_cmd_vld = 1'b0;
        clear_stages();
        mq.delete();
        m_vld = 1'b0;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick(1'b0, '0, acc);
            checks++; if (o_upd_vld_r !== 1'b0) begin errors++; $display("FAIL rst_stale[%0d] got vld %b exp 0", n, o_upd_vld_r); end
        end
        fresh = mk(5, 'h555, 5);
        tick(1'b1, fresh, acc);
        checks++; if (o_upd_vld_r !== 1'b1 || dut_upd() !== fresh) begin
            errors++; $display("FAIL rst_fresh got vld %b %h exp 1 %h", o_upd_vld_r, dut_upd(), fresh); end
        tick(1'b0, '0, acc);
    endtask

    initial begin
        clear_stages();
        test_reset();
        test_single();
        test_back_to_back();
`ifdef V_UPD_ISSUE_HAZARD_STALL_EN
        test_hazard_order();
        test_hazard_full();
`else
        test_same_product();
`endif
        test_random();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
